// File: rtl/use_proto_pkg.sv
// Shared framing constants for the UART control protocol. The transmit-side frame builder and
// the receive-side parser both import this, so the two ends agree on layout and byte positions.
package use_proto_pkg;

    localparam int unsigned FRAME_LEN = 8;

    localparam logic [7:0] DEF_HEAD0 = 8'hAB;
    localparam logic [7:0] DEF_HEAD1 = 8'hCD;
    localparam logic [7:0] DEF_TAIL  = 8'hEF;

    // Byte positions within a frame; time is carried little-endian.
    localparam int unsigned IDX_HEAD0 = 0;
    localparam int unsigned IDX_HEAD1 = 1;
    localparam int unsigned IDX_CTRL  = 2;
    localparam int unsigned IDX_T0    = 3;
    localparam int unsigned IDX_T1    = 4;
    localparam int unsigned IDX_T2    = 5;
    localparam int unsigned IDX_T3    = 6;
    localparam int unsigned IDX_TAIL  = 7;

    typedef logic [FRAME_LEN-1:0][7:0] frame_t;

    function automatic frame_t build_frame(input logic [7:0]  head0,
                                           input logic [7:0]  head1,
                                           input logic [7:0]  tail,
                                           input logic [7:0]  ctrl,
                                           input logic [31:0] time_val);
        frame_t f;
        f            = '0;
        f[IDX_HEAD0] = head0;
        f[IDX_HEAD1] = head1;
        f[IDX_CTRL]  = ctrl;
        f[IDX_T0]    = time_val[7:0];
        f[IDX_T1]    = time_val[15:8];
        f[IDX_T2]    = time_val[23:16];
        f[IDX_T3]    = time_val[31:24];
        f[IDX_TAIL]  = tail;
        return f;
    endfunction

endpackage

// File: rtl/use_send.sv
// Transmit-side frame builder: latches ctrl/time_ctrl on a request and feeds the 8-byte frame
// one byte at a time to uart_tx, with a per-byte timeout on tx_done. All outputs are registered.
module use_send
    import use_proto_pkg::*;
#(
    parameter logic [7:0]  HEAD0      = DEF_HEAD0,
    parameter logic [7:0]  HEAD1      = DEF_HEAD1,
    parameter logic [7:0]  TAIL       = DEF_TAIL,
    parameter int unsigned TX_TIMEOUT = 50000
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [7:0]  ctrl,
    input  logic [31:0] time_ctrl,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic        req_drop
);

    // A zero timeout disables the counter; keep it one bit wide so it still elaborates.
    localparam int unsigned CNT_W = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TX_TIMEOUT > 0) ? CNT_W'(TX_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e           state_q, state_d;
    frame_t           frame_q, frame_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             req_drop_q, req_drop_d;

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        req_drop_d   = 1'b0;

        // Only IDLE accepts requests; anything else is dropped and reported.
        if (send_req && (state_q != StIdle)) begin
            req_drop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (send_req) begin
                    frame_d    = build_frame(HEAD0, HEAD1, TAIL, ctrl, time_ctrl);
                    idx_d      = 3'd0;
                    tx_start_d = 1'b1;
                    tx_data_d  = HEAD0;
                    busy_d     = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // tx_done wins over a timeout expiring in the same cycle.
                if (tx_done) begin
                    if (idx_q == 3'd7) begin
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_start_d = 1'b1;
                        tx_data_d  = frame_q[idx_q + 3'd1];
                        state_d    = StSend;
                    end
                end else if ((TX_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else if ((TX_TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, frame latch, index, timeout counter and output registers; reset abandons any frame.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            tx_data_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            req_drop_q   <= req_drop_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_use_send.sv
// Bench for use_send: a uart_tx stand-in answers each tx_start with tx_done, and a scoreboard
// of expected frame bytes is checked as each byte is started.
module tb_use_send;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        send_req = 1'b0;
    logic [7:0]  ctrl = 8'd0;
    logic [31:0] time_ctrl = 32'd0;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic        req_drop;

    use_send #(
        .TX_TIMEOUT(10)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .send_req   (send_req),
        .ctrl       (ctrl),
        .time_ctrl  (time_ctrl),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .req_drop   (req_drop)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [7:0] exp_q[$];
    int         req_cyc = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    bit         first_pending = 1'b0;
    int         bidx = 0;
    int         withhold_idx = -1;
    int         done_dly = 3;
    int         n_fdone = 0;
    int         n_ferr = 0;
    int         n_drop = 0;
    logic [7:0] last_start = 8'd0;
    int         f0, e0, d0;

    // Monitor: scoreboard on every tx_start, latency and hold checks, pulse counters.
    initial begin
        forever begin
            @(negedge sclk);
            if (tx_start) begin
                start_cyc  = cyc;
                last_start = tx_data;
                chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
                if (first_pending) begin
                    chk("lat_req", cyc, req_cyc + 1);
                    first_pending = 1'b0;
                end else begin
                    chk("lat_done", cyc, done_cyc + 1);
                end
            end
            if (tx_done && busy) chk("tx_hold", tx_data, last_start);
            if (frame_done) n_fdone++;
            if (frame_err) n_ferr++;
            if (req_drop) n_drop++;
        end
    end

    // uart_tx stand-in: tx_done done_dly cycles after tx_start, except for a withheld byte.
    initial begin
        int b;
        forever begin
            @(negedge sclk);
            if (tx_start) begin
                b = bidx;
                bidx++;
                if (b != withhold_idx) begin
                    repeat (done_dly) @(posedge sclk);
                    #1 tx_done = 1'b1;
                    done_cyc = cyc;
                    @(posedge sclk);
                    #1 tx_done = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [31:0] t);
        send_req  = 1'b1;
        ctrl      = c;
        time_ctrl = t;
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        exp_q.push_back(c);
        exp_q.push_back(t[7:0]);
        exp_q.push_back(t[15:8]);
        exp_q.push_back(t[23:16]);
        exp_q.push_back(t[31:24]);
        exp_q.push_back(8'hEF);
        req_cyc       = cyc;
        first_pending = 1'b1;
        bidx          = 0;
        @(posedge sclk);
        #1;
        send_req  = 1'b0;
        ctrl      = 8'($urandom);
        time_ctrl = $urandom;
        @(negedge sclk);
        chk("busy_hi", busy, 1);
    endtask

    task automatic wait_idle(input int lim);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge sclk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idle_reached", 64'(seen), 1);
    endtask

    task automatic wait_bidx(input int n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge sclk);
            if (bidx >= n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("byte_reached", 64'(seen), 1);
    endtask

    task automatic snap();
        f0 = n_fdone;
        e0 = n_ferr;
        d0 = n_drop;
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_out", {tx_start, busy, frame_done, frame_err, req_drop, tx_data}, 0);
        @(posedge sclk);
        #1 rst = 1'b0;
        @(posedge sclk);
        #1;

        // Basic frame
        snap();
        send(8'h5A, 32'h12345678);
        wait_idle(200);
        chk("f1_done", n_fdone - f0, 1);
        chk("f1_err", n_ferr - e0, 0);
        chk("f1_sb", exp_q.size(), 0);

        // Request while busy is dropped; frame keeps its latched bytes
        snap();
        send(8'h21, 32'hA1B2C3D4);
        wait_bidx(4);
        @(posedge sclk);
        #1;
        send_req  = 1'b1;
        ctrl      = 8'hFF;
        time_ctrl = 32'h99999999;
        @(posedge sclk);
        #1 send_req = 1'b0;
        wait_idle(200);
        chk("drop_cnt", n_drop - d0, 1);
        chk("drop_done", n_fdone - f0, 1);
        chk("drop_sb", exp_q.size(), 0);

        // Back-to-back request in the first idle cycle
        snap();
        send(8'hFF, 32'hDEADBEEF);
        wait_idle(200);
        chk("b2b_done", n_fdone - f0, 1);
        chk("b2b_drop", n_drop - d0, 0);
        chk("b2b_sb", exp_q.size(), 0);

        // Timeout: byte 2 never completes
        @(posedge sclk);
        #1;
        withhold_idx = 2;
        snap();
        send(8'h33, 32'h0BADF00D);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (frame_err) begin
                seen = 1'b1;
                break;
            end
            @(negedge sclk);
        end
        chk("to_seen", 64'(seen), 1);
        chk("to_lat", cyc, start_cyc + 11);
        @(negedge sclk);
        chk("to_pulse", frame_err, 0);
        chk("to_busy", busy, 0);
        chk("to_err_cnt", n_ferr - e0, 1);
        chk("to_nodone", n_fdone - f0, 0);
        chk("to_left", exp_q.size(), 5);
        exp_q.delete();
        withhold_idx = -1;

        // Reset while waiting on byte 5, then a fresh frame
        @(posedge sclk);
        #1;
        withhold_idx = 5;
        snap();
        send(8'h44, 32'h55667788);
        wait_bidx(6);
        @(posedge sclk);
        #1 rst = 1'b1;
        @(posedge sclk);
        #1 rst = 1'b0;
        @(negedge sclk);
        chk("rst_mid", {tx_start, busy, frame_done, frame_err, req_drop, tx_data}, 0);
        chk("rst_left", exp_q.size(), 2);
        chk("rst_nodone", n_fdone - f0, 0);
        chk("rst_noerr", n_ferr - e0, 0);
        exp_q.delete();
        withhold_idx = -1;
        @(posedge sclk);
        #1;
        snap();
        send(8'h5A, 32'h12345678);
        wait_idle(200);
        chk("rr_done", n_fdone - f0, 1);
        chk("rr_sb", exp_q.size(), 0);

        // tx_done lands exactly on the expiry cycle for every byte
        done_dly = 10;
        snap();
        send(8'h77, 32'h01020304);
        wait_idle(500);
        chk("edge_noerr", n_ferr - e0, 0);
        chk("edge_done", n_fdone - f0, 1);
        chk("edge_sb", exp_q.size(), 0);
        done_dly = 3;

        repeat (2) @(posedge sclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0d cycles, expected finish", cyc);
        $fatal(1);
    end

endmodule
